// File: rtl/fu_result_buffer.sv
// Per-FU result buffer feeding the CDB: an in-order, compacted queue whose head
// is offered on fub_*; supports CDB pop, branch squash and branch-bit clearing.
module fu_result_buffer #(
  parameter int DEPTH   = 4,
  parameter int PHYS_W  = 6,
  parameter int DATA_W  = 64,
  parameter int BMASK_W = 4,
  parameter int BSPTR_W = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               fu_valid,
  input  logic [PHYS_W-1:0]  fu_tagDest,
  input  logic [DATA_W-1:0]  fu_result,
  input  logic [BMASK_W-1:0] fu_bmask,
  input  logic               cdb_stall,
  input  logic               br_pred_wrong,
  input  logic               br_pred_correct,
  input  logic [BSPTR_W-1:0] br_bs_ptr,
  output logic               fub_valid,
  output logic [PHYS_W-1:0]  fub_tagDest,
  output logic [DATA_W-1:0]  fub_result,
  output logic [BMASK_W-1:0] fub_bmask,
  output logic               fub_full
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PHYS_W-1:0]  tag_q [DEPTH];
  logic [PHYS_W-1:0]  tag_d [DEPTH];
  logic [DATA_W-1:0]  res_q [DEPTH];
  logic [DATA_W-1:0]  res_d [DEPTH];
  logic [BMASK_W-1:0] bm_q  [DEPTH];
  logic [BMASK_W-1:0] bm_d  [DEPTH];
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;

  logic               live_c [DEPTH];
  logic [BMASK_W-1:0] bmclr_c [DEPTH];
  logic [BMASK_W-1:0] in_bm_c;
  logic               pop_c;
  logic               full_c;
  logic               push_c;
  logic [CNT_W-1:0]   wr_idx;

  assign full_c = (count_q == CNT_W'(DEPTH));
  assign pop_c  = (count_q != '0) && !cdb_stall;

  // Survivors after pop and branch resolution; mispredict overrides a
  // simultaneous correct-resolve.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      live_c[i]  = (CNT_W'(i) < count_q) && !((i == 0) && pop_c);
      bmclr_c[i] = bm_q[i];
      if (br_pred_wrong) begin
        if (bm_q[i][br_bs_ptr]) live_c[i] = 1'b0;
      end else if (br_pred_correct) begin
        bmclr_c[i][br_bs_ptr] = 1'b0;
      end
    end
  end

  always_comb begin
    in_bm_c = fu_bmask;
    if (!br_pred_wrong && br_pred_correct) in_bm_c[br_bs_ptr] = 1'b0;
    push_c = fu_valid && !full_c && !(br_pred_wrong && fu_bmask[br_bs_ptr]);
  end

  // Compact survivors toward slot 0, then append the incoming result.
  // Unused slots are kept zero so the storage always mirrors the queue.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      tag_d[i] = '0;
      res_d[i] = '0;
      bm_d[i]  = '0;
    end
    wr_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_c[i]) begin
        tag_d[wr_idx[IDX_W-1:0]] = tag_q[i];
        res_d[wr_idx[IDX_W-1:0]] = res_q[i];
        bm_d[wr_idx[IDX_W-1:0]]  = bmclr_c[i];
        wr_idx = wr_idx + 1'b1;
      end
    end
    if (push_c) begin
      tag_d[wr_idx[IDX_W-1:0]] = fu_tagDest;
      res_d[wr_idx[IDX_W-1:0]] = fu_result;
      bm_d[wr_idx[IDX_W-1:0]]  = in_bm_c;
      wr_idx = wr_idx + 1'b1;
    end
    count_d = wr_idx;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
        res_q[i] <= '0;
        bm_q[i]  <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= tag_d[i];
        res_q[i] <= res_d[i];
        bm_q[i]  <= bm_d[i];
      end
    end
  end

  assign fub_valid   = (count_q != '0);
  assign fub_full    = full_c;
  assign fub_tagDest = fub_valid ? tag_q[0] : '0;
  assign fub_result  = fub_valid ? res_q[0] : '0;
  assign fub_bmask   = fub_valid ? bm_q[0]  : '0;

endmodule

// File: tb/tb_fu_result_buffer.sv
// Bench for fu_result_buffer: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based model of the buffer.
module tb_fu_result_buffer;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        fu_valid;
  logic [5:0]  fu_tagDest;
  logic [63:0] fu_result;
  logic [3:0]  fu_bmask;
  logic        cdb_stall;
  logic        br_pred_wrong;
  logic        br_pred_correct;
  logic [1:0]  br_bs_ptr;
  logic        fub_valid;
  logic [5:0]  fub_tagDest;
  logic [63:0] fub_result;
  logic [3:0]  fub_bmask;
  logic        fub_full;

  typedef struct packed {
    logic [5:0]  tag;
    logic [63:0] res;
    logic [3:0]  bm;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;

  fu_result_buffer #(.DEPTH(DEPTH), .PHYS_W(6), .DATA_W(64), .BMASK_W(4), .BSPTR_W(2)) dut (
    .clock(clock), .reset(reset), .fu_valid(fu_valid), .fu_tagDest(fu_tagDest),
    .fu_result(fu_result), .fu_bmask(fu_bmask), .cdb_stall(cdb_stall),
    .br_pred_wrong(br_pred_wrong), .br_pred_correct(br_pred_correct), .br_bs_ptr(br_bs_ptr),
    .fub_valid(fub_valid), .fub_tagDest(fub_tagDest), .fub_result(fub_result),
    .fub_bmask(fub_bmask), .fub_full(fub_full)
  );

  always #5 clock = ~clock;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    ent_t h;
    logic v;
    v = (q.size() > 0);
    h = v ? q[0] : '0;
    cmp("valid", 64'(fub_valid), 64'(v));
    cmp("full", 64'(fub_full), 64'(q.size() == DEPTH));
    cmp("tag", 64'(fub_tagDest), 64'(h.tag));
    cmp("result", fub_result, h.res);
    cmp("bmask", 64'(fub_bmask), 64'(h.bm));
  endtask

  task automatic model_update(input logic rst, input logic fv, input ent_t in,
                              input logic stall, input logic wr, input logic cr,
                              input logic [1:0] ptr);
    ent_t nq[$];
    ent_t e;
    logic was_full;
    if (rst) begin
      q.delete();
      return;
    end
    was_full = (q.size() == DEPTH);
    if (q.size() > 0 && !stall) void'(q.pop_front());
    foreach (q[i]) begin
      e = q[i];
      if (wr) begin
        if (!e.bm[ptr]) nq.push_back(e);
      end else begin
        if (cr) e.bm[ptr] = 1'b0;
        nq.push_back(e);
      end
    end
    q = nq;
    if (fv && !was_full) begin
      e = in;
      if (!(wr && e.bm[ptr])) begin
        if (!wr && cr) e.bm[ptr] = 1'b0;
        q.push_back(e);
      end
    end
  endtask

  task automatic step(input logic rst, input logic fv, input logic [5:0] tag,
                      input logic [63:0] res, input logic [3:0] bm, input logic stall,
                      input logic wr, input logic cr, input logic [1:0] ptr);
    ent_t in;
    reset = rst; fu_valid = fv; fu_tagDest = tag; fu_result = res; fu_bmask = bm;
    cdb_stall = stall; br_pred_wrong = wr; br_pred_correct = cr; br_bs_ptr = ptr;
    in.tag = tag; in.res = res; in.bm = bm;
    #1;
    check_model();
    @(posedge clock);
    model_update(rst, fv, in, stall, wr, cr, ptr);
    @(negedge clock);
  endtask

  task automatic push(input logic [5:0] tag, input logic [3:0] bm);
    step(1'b0, 1'b1, tag, {58'h0, tag} + 64'h1000, bm, 1'b1, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic idle(input logic stall);
    step(1'b0, 1'b0, 6'd0, 64'd0, 4'd0, stall, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    reset = 1'b1; fu_valid = 1'b0; fu_tagDest = '0; fu_result = '0; fu_bmask = '0;
    cdb_stall = 1'b1; br_pred_wrong = 1'b0; br_pred_correct = 1'b0; br_bs_ptr = '0;
    @(negedge clock);

    // Reset held two cycles with a pending FU result
    step(1'b1, 1'b1, 6'd3, 64'h55, 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b1, 6'd3, 64'h55, 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0);
    idle(1'b1);
    cmp("rst_valid", 64'(fub_valid), 64'd0);
    cmp("rst_full", 64'(fub_full), 64'd0);
    cmp("rst_result", fub_result, 64'd0);

    // Basic latency and pop
    step(1'b0, 1'b1, 6'd5, 64'hDEAD_BEEF, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0);
    cmp("lat_valid", 64'(fub_valid), 64'd1);
    cmp("lat_tag", 64'(fub_tagDest), 64'd5);
    cmp("lat_result", fub_result, 64'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) idle(1'b1);
    cmp("hold_tag", 64'(fub_tagDest), 64'd5);
    idle(1'b0);
    cmp("pop_empty", 64'(fub_valid), 64'd0);

    // Fill, overflow drop, drain in order
    for (int t = 1; t <= 4; t++) push(6'(t), 4'b0000);
    cmp("fill_full", 64'(fub_full), 64'd1);
    push(6'd9, 4'b0000);
    cmp("drop_full", 64'(fub_full), 64'd1);
    for (int t = 1; t <= 4; t++) begin
      cmp("drain_tag", 64'(fub_tagDest), 64'(t));
      idle(1'b0);
    end
    cmp("drain_empty", 64'(fub_valid), 64'd0);

    // Squash with compaction; incoming tag 7 on the squashed branch
    push(6'd1, 4'b0001); push(6'd2, 4'b0010); push(6'd3, 4'b0000); push(6'd4, 4'b0010);
    step(1'b0, 1'b1, 6'd7, 64'h77, 4'b0010, 1'b1, 1'b1, 1'b0, 2'd1);
    cmp("sq_full", 64'(fub_full), 64'd0);
    cmp("sq_head", 64'(fub_tagDest), 64'd1);
    cmp("sq_model_cnt", 64'(q.size()), 64'd2);
    idle(1'b0);
    cmp("sq_next", 64'(fub_tagDest), 64'd3);
    idle(1'b0);
    cmp("sq_empty", 64'(fub_valid), 64'd0);

    // Correct resolve clears stored and incoming bits
    push(6'd6, 4'b0110);
    step(1'b0, 1'b1, 6'd8, 64'h88, 4'b0100, 1'b1, 1'b0, 1'b1, 2'd2);
    cmp("cr_bm", 64'(fub_bmask), 64'b0010);
    step(1'b0, 1'b0, 6'd0, 64'd0, 4'd0, 1'b1, 1'b1, 1'b0, 2'd2);
    cmp("cr_model_cnt", 64'(q.size()), 64'd2);
    cmp("cr_head", 64'(fub_tagDest), 64'd6);
    idle(1'b0);
    cmp("cr_tag2", 64'(fub_tagDest), 64'd8);
    cmp("cr_bm2", 64'(fub_bmask), 64'b0000);
    idle(1'b0);

    // Pop + push + squash in one edge
    push(6'd1, 4'b0000); push(6'd2, 4'b1000);
    step(1'b0, 1'b1, 6'd3, 64'h33, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd3);
    cmp("mix_head", 64'(fub_tagDest), 64'd3);
    cmp("mix_model_cnt", 64'(q.size()), 64'd1);
    idle(1'b0);

    // Randomized traffic; FU never pushes into a full buffer
    for (int n = 0; n < 3000; n++) begin
      logic rst, fv, wr, cr;
      rst = ($urandom_range(99) == 0);
      fv  = ($urandom_range(1) == 1) && (q.size() != DEPTH);
      wr  = ($urandom_range(9) == 0);
      cr  = ($urandom_range(9) == 0);
      step(rst, fv, 6'($urandom), {$urandom, $urandom}, 4'($urandom),
           ($urandom_range(2) != 0), wr, cr, 2'($urandom));
    end
    idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
